// File: rtl/l2_line_responder.sv
// Responder for line-granular L2 requests: a 128-bit line is moved as eight
// 16-bit beats over a req/ack word memory port, then acknowledged with l2_resp.
module l2_line_responder (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   l2_addr,
    input  logic [127:0]  l2_wdata,
    input  logic          l2_read,
    input  logic          l2_write,
    output logic [127:0]  l2_rdata,
    output logic          l2_resp,
    output logic [15:0]   mem_addr,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic          mem_ack
);

    localparam int unsigned WORD_W = 16;
    localparam int unsigned LINE_W = 128;
    localparam int unsigned BEAT_W = 3;
    localparam int unsigned BASE_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [BASE_W-1:0]   base_q, base_d;
    logic [LINE_W-1:0]   wbuf_q, wbuf_d;
    logic [LINE_W-1:0]   rbuf_d;
    logic [WORD_W-1:0]   mem_addr_d, mem_wdata_d;
    logic                last_beat;

    assign last_beat = (beat_q == BEAT_W'(7));

    // Next-state, datapath updates, and next values of the registered outputs
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        base_d      = base_q;
        wbuf_d      = wbuf_q;
        rbuf_d      = l2_rdata;
        mem_addr_d  = '0;
        mem_wdata_d = '0;

        case (state_q)
            IDLE: begin
                if (l2_write) begin
                    base_d  = l2_addr[15:4];
                    wbuf_d  = l2_wdata;
                    beat_d  = '0;
                    state_d = WRITE;
                end else if (l2_read) begin
                    base_d  = l2_addr[15:4];
                    beat_d  = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (mem_ack) begin
                    rbuf_d[{beat_q, 4'b0000} +: WORD_W] = mem_rdata;
                    beat_d = beat_q + BEAT_W'(1);
                    if (last_beat) state_d = RESP;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (last_beat) state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Base has zero low nibble, so the beat index never carries out of the line
        if (state_d == READ || state_d == WRITE) begin
            mem_addr_d = {base_d, beat_d, 1'b0};
        end
        if (state_d == WRITE) begin
            mem_wdata_d = wbuf_d[{beat_d, 4'b0000} +: WORD_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            base_q    <= '0;
            wbuf_q    <= '0;
            l2_rdata  <= '0;
            l2_resp   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            base_q    <= base_d;
            wbuf_q    <= wbuf_d;
            l2_rdata  <= rbuf_d;
            l2_resp   <= (state_d == RESP);
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_read  <= (state_d == READ);
            mem_write <= (state_d == WRITE);
        end
    end

endmodule

// File: tb/tb_l2_line_responder.sv
// Directed bench for l2_line_responder: vector table of line transactions
// against a wait-state word memory, plus reset sequences.
module tb_l2_line_responder;

    logic          clk;
    logic          rst_n;
    logic [15:0]   l2_addr;
    logic [127:0]  l2_wdata;
    logic          l2_read;
    logic          l2_write;
    logic [127:0]  l2_rdata;
    logic          l2_resp;
    logic [15:0]   mem_addr;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;
    logic          mem_read;
    logic          mem_write;
    logic          mem_ack;

    int unsigned   wait_n;
    int unsigned   wait_cnt;
    logic [15:0]   rbase;
    int            cyc;
    int            n_tests;
    int            n_fail;
    int            prev_resp;

    l2_line_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .l2_addr   (l2_addr),
        .l2_wdata  (l2_wdata),
        .l2_read   (l2_read),
        .l2_write  (l2_write),
        .l2_rdata  (l2_rdata),
        .l2_resp   (l2_resp),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Word memory: acks after wait_n stall cycles, read data = rbase + word index
    always @(posedge clk) begin
        if (!(mem_read || mem_write) || mem_ack) wait_cnt <= 0;
        else                                      wait_cnt <= wait_cnt + 1;
    end
    assign mem_ack   = (mem_read || mem_write) && (wait_cnt == wait_n);
    assign mem_rdata = rbase + 16'(mem_addr[3:1]);

    typedef struct {
        string         name;
        logic          rd;
        logic          wr;
        logic [15:0]   addr;
        logic [127:0]  wdata;
        int unsigned   wait_n;
        logic [15:0]   rbase;
        logic [15:0]   exp_base;
        int            exp_resp;
        logic [127:0]  exp_rdata;
        logic          chained;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Request held from cycle 0 until l2_resp; address/data scrambled after acceptance
    task automatic run_vec(input vec_t v);
        int beats;
        int resp_cyc;
        logic bad_beat;
        @(posedge clk); #1;
        chk({v.name, "_resp_low_idle"}, 128'(l2_resp), 128'(0));
        wait_n   = v.wait_n;
        rbase    = v.rbase;
        l2_addr  = v.addr;
        l2_wdata = v.wdata;
        l2_read  = v.rd;
        l2_write = v.wr;
        beats    = 0;
        resp_cyc = 0;
        bad_beat = 1'b0;
        for (int c = 1; c <= 200 && resp_cyc == 0; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                l2_addr  = ~v.addr;
                l2_wdata = ~v.wdata;
            end
            if (l2_resp) begin
                resp_cyc = c;
                chk({v.name, "_resp_spacing"}, 128'(v.chained ? cyc - prev_resp : v.exp_resp + 1),
                    128'(v.exp_resp + 1));
                prev_resp = cyc;
                chk({v.name, "_port_idle_in_resp"}, 128'({mem_read, mem_write}), 128'(0));
            end else begin
                if (beats > 7 || mem_read !== !v.wr || mem_write !== v.wr ||
                    mem_addr !== v.exp_base + 16'(2 * beats) ||
                    (v.wr && mem_wdata !== v.wdata[16*beats +: 16])) begin
                    if (!bad_beat)
                        $display("FAIL %s_beat: beat %0d cycle %0d got rd=%b wr=%b addr=%h wdata=%h",
                                 v.name, beats, c, mem_read, mem_write, mem_addr, mem_wdata);
                    bad_beat = 1'b1;
                end
                if (mem_ack) beats++;
            end
        end
        l2_read  = 1'b0;
        l2_write = 1'b0;
        n_tests++;
        if (bad_beat) n_fail++;
        chk({v.name, "_resp_cycle"}, 128'(resp_cyc), 128'(v.exp_resp));
        chk({v.name, "_beats"}, 128'(beats), 128'(8));
        chk({v.name, "_rdata"}, l2_rdata, v.exp_rdata);
    endtask

    initial begin
        logic found;
        n_tests = 0; n_fail = 0; cyc = 0; prev_resp = 0;
        wait_n = 0; rbase = 16'h0000;
        l2_addr = 16'h7770; l2_wdata = '0; l2_write = 1'b0; l2_read = 1'b1;
        rst_n = 1'b0;

        tbl[0] = '{"rd_zero_wait", 1'b1, 1'b0, 16'h1234, 128'h0, 0, 16'h1000, 16'h1230, 9,
                   {16'h1007, 16'h1006, 16'h1005, 16'h1004, 16'h1003, 16'h1002, 16'h1001, 16'h1000}, 1'b1};
        tbl[1] = '{"wr_stall2", 1'b0, 1'b1, 16'h4008,
                   {16'h00A7, 16'h00A6, 16'h00A5, 16'h00A4, 16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0},
                   2, 16'hDEAD, 16'h4000, 25,
                   {16'h1007, 16'h1006, 16'h1005, 16'h1004, 16'h1003, 16'h1002, 16'h1001, 16'h1000}, 1'b1};
        tbl[2] = '{"rd_wr_both", 1'b1, 1'b1, 16'h2000,
                   {16'h00C7, 16'h00C6, 16'h00C5, 16'h00C4, 16'h00C3, 16'h00C2, 16'h00C1, 16'h00C0},
                   0, 16'hDEAD, 16'h2000, 9,
                   {16'h1007, 16'h1006, 16'h1005, 16'h1004, 16'h1003, 16'h1002, 16'h1001, 16'h1000}, 1'b1};
        tbl[3] = '{"rd_stall1", 1'b1, 1'b0, 16'h0FFE, 128'h0, 1, 16'hBEE0, 16'h0FF0, 17,
                   {16'hBEE7, 16'hBEE6, 16'hBEE5, 16'hBEE4, 16'hBEE3, 16'hBEE2, 16'hBEE1, 16'hBEE0}, 1'b1};
        tbl[4] = '{"rd_after_rst", 1'b1, 1'b0, 16'h3000, 128'h0, 0, 16'h3300, 16'h3000, 9,
                   {16'h3307, 16'h3306, 16'h3305, 16'h3304, 16'h3303, 16'h3302, 16'h3301, 16'h3300}, 1'b0};

        // Reset with a read pending: everything quiet until release
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp", 128'(l2_resp), 128'(0));
        chk("rst_rdata", l2_rdata, 128'(0));
        chk("rst_mem_rw", 128'({mem_read, mem_write}), 128'(0));
        chk("rst_mem_addr", 128'(mem_addr), 128'(0));
        chk("rst_mem_wdata", 128'(mem_wdata), 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_read_entered", 128'(mem_read), 128'(1));
        chk("rel_first_addr", 128'(mem_addr), 128'(16'h7770));
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(posedge clk); #1;
            if (l2_resp) found = 1'b1;
        end
        l2_read = 1'b0;
        prev_resp = cyc;
        chk("rel_resp_seen", 128'(found), 128'(1));
        chk("rel_rdata", l2_rdata,
            {16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000});

        for (int i = 0; i < 4; i++) run_vec(tbl[i]);

        // Reset during beat 4 of a read: port drops at once, no response follows
        @(posedge clk); #1;
        wait_n = 0; rbase = 16'h5500; l2_addr = 16'h5000; l2_read = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk); #1;
            if (mem_addr == 16'h5008 && mem_read) found = 1'b1;
        end
        chk("midrst_beat4_reached", 128'(found), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mem_read_async", 128'(mem_read), 128'(0));
        chk("midrst_mem_addr_async", 128'(mem_addr), 128'(0));
        chk("midrst_rdata_cleared", l2_rdata, 128'(0));
        l2_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (l2_resp || mem_read || mem_write) found = 1'b1;
        end
        chk("midrst_no_resp", 128'(found), 128'(0));

        run_vec(tbl[4]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_line_responder.md
# l2_line_responder

Responder end of the line-granular L2 request interface driven by the cache arbiter. Accepts one 128-bit line read or write at a time (`l2_read`/`l2_write`, held until `l2_resp`). Services it as eight sequential 16-bit word beats on a narrow memory port with a req/ack handshake, then returns the assembled line with a one-cycle `l2_resp` pulse. Sits between the arbiter's L2 port and word-wide backing memory.

## Interface
- No parameters. Line = 8 × 16-bit words (`lc3b_line` 128 b, `lc3b_word` 16 b), fixed.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `l2_addr` in 16: byte address of the request; bits [3:0] ignored (line-aligned).
- `l2_wdata` in 128: write line; word k = bits [16k+15:16k].
- `l2_read` in 1: read request, held until `l2_resp`.
- `l2_write` in 1: write request, held until `l2_resp`.
- `l2_rdata` out 128: last read line; valid in `l2_resp` cycle of a read, then held.
- `l2_resp` out 1: one-cycle completion pulse.
- `mem_addr` out 16: word byte-address of the current beat.
- `mem_wdata` out 16: write word for the current beat.
- `mem_rdata` in 16: read word, sampled when `mem_ack`=1 during a read beat.
- `mem_read` out 1: read beat request, held until `mem_ack`.
- `mem_write` out 1: write beat request, held until `mem_ack`.
- `mem_ack` in 1: beat complete; ignored when neither `mem_read` nor `mem_write` is asserted.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - `l2_write`=1 → latch base `{l2_addr[15:4],4'b0}` and `l2_wdata`; beat←0; go to WRITE.
  - else `l2_read`=1 → latch base; beat←0; go to READ.
  - Write wins if both requests are high.
- READ: `mem_read`=1, `mem_addr`=base+2·beat. On `mem_ack`: rbuf word[beat]←`mem_rdata`; beat++. Ack on beat 7 → RESP.
- WRITE: `mem_write`=1, same address rule, `mem_wdata`=latched word[beat]. On `mem_ack`: beat++. Ack on beat 7 → RESP.
- RESP: `l2_resp`=1 for exactly one cycle, then IDLE. No request is sampled in RESP.
- Beat counter is 3 bits. Address arithmetic never carries out of the line, because base[3:0]=0.
- `l2_rdata` = rbuf at all times. A write does not modify rbuf.
- A request deasserted mid-transaction is a protocol violation: the transaction still completes and `l2_resp` still pulses.
- Address and write data changed mid-transaction are ignored; latched copies are used.
- Async reset at any point:
  - State → IDLE, beat → 0, rbuf and write latch → 0.
  - All outputs → 0 immediately.
  - The in-flight transaction is abandoned; no `l2_resp`.

## Timing
- Reset values: `l2_resp`=0, `l2_rdata`=0, `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
- All memory-port outputs and `l2_resp` decode from registered state, beat and latches only; no input-to-output combinational path.
- Cycle count, with the request first seen in IDLE at cycle 0:
  - Beats occupy cycles 1..N, where N = 8 + total `mem_ack` wait cycles.
  - `l2_resp` is high in cycle N+1.
  - Zero-wait memory gives `l2_resp` in cycle 9.
- Beat k advances on the edge where `mem_ack`=1. The next beat's address appears the following cycle.
- Back-to-back: IDLE is entered the cycle after RESP. A new request held there is accepted with no extra bubble, so the minimum spacing between `l2_resp` pulses is 10 cycles.

## Test plan
1. Reset:
   - Assert `rst_n`=0 with `l2_read`=1 → all outputs 0.
   - Release → READ entered the cycle after the first IDLE sample.
2. Read, zero-wait:
   - Stimulus: `l2_addr`=16'h1234, memory returns 16'h1000+k, `mem_ack` tied to `mem_read`.
   - `mem_addr` = 1230, 1232, …, 123E in cycles 1..8.
   - `l2_resp` high only in cycle 9.
   - `l2_rdata` = {1007,1006,…,1000}.
3. Write with stalls:
   - Stimulus: `l2_addr`=16'h4008, `l2_wdata` words 16'hA0..A7, `mem_ack` 2 cycles after each `mem_write` rise.
   - `mem_addr` 4000..400E with `mem_wdata` A0..A7 in order.
   - `l2_resp` in cycle 25.
   - `l2_rdata` unchanged.
4. Back-to-back:
   - Read completes; requester raises `l2_write` in the cycle after `l2_resp`.
   - Write accepted that cycle, exactly 8 beats, second `l2_resp` 10 cycles after the first.
5. Both `l2_read` and `l2_write` high at 0x2000 → only `mem_write` beats occur, one `l2_resp`.
6. Reset mid-read:
   - Pulse `rst_n` low during beat 4 → `mem_read` drops asynchronously, no `l2_resp`.
   - Subsequent read at 0x3000 runs beats 0..7 from 0x3000.
